// File: rtl/riscv_ex_pipe.sv
// Registered execute stage: ALU, branch/jump resolution and an optional
// radix-2 iterative multiplier, with valid/ready handshakes and flush.
module riscv_ex_pipe #(
  parameter int              XLEN   = 32,
  parameter bit              MUL_EN = 1'b1,
  parameter logic [XLEN-1:0] PC_RST = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [3:0]      alu_op_i,
  input  logic [XLEN-1:0] alu_a_i,
  input  logic [XLEN-1:0] alu_b_i,
  input  logic [XLEN-1:0] cmp_a_i,
  input  logic [XLEN-1:0] cmp_b_i,
  input  logic [XLEN-1:0] offset_i,
  input  logic            br_i,
  input  logic [2:0]      br_cond_i,
  input  logic            jal_i,
  input  logic            jalr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            redirect_o
);

  localparam int              SHW      = $clog2(XLEN);
  localparam int              CW       = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] FOUR     = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0] LSB_MASK = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state_r, state_nxt_s;
  logic              accept_s, is_mul_s, br_cond_s, redirect_s;
  logic [XLEN-1:0]   alu_res_s, result_s, pc_next_s, pc_plus4_s, acc_step_s;
  logic [XLEN-1:0]   mcand_r, mplier_r, acc_r;
  logic [CW-1:0]     cnt_r;

  // Op codes 10 (when no multiplier is built) and 11-15 fall back to ADD.
  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      4'd1:    alu_f = a - b;
      4'd2:    alu_f = a & b;
      4'd3:    alu_f = a | b;
      4'd4:    alu_f = a ^ b;
      4'd5:    alu_f = a << sh;
      4'd6:    alu_f = a >> sh;
      4'd7:    alu_f = $signed(a) >>> sh;
      4'd8:    alu_f = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9:    alu_f = {{(XLEN-1){1'b0}}, (a < b)};
      default: alu_f = a + b;
    endcase
  endfunction

  assign accept_s   = in_valid_i & in_ready_o & ~flush_i;
  assign is_mul_s   = MUL_EN && (alu_op_i == 4'd10) && !jal_i && !jalr_i;
  assign pc_plus4_s = pc_i + FOUR;
  assign alu_res_s  = alu_f(alu_op_i, alu_a_i, alu_b_i);
  assign acc_step_s = acc_r + (mplier_r[0] ? mcand_r : ZERO);

  // Branch condition evaluation on the dedicated compare operands.
  always_comb begin
    br_cond_s = 1'b0;
    case (br_cond_i)
      3'b000:  br_cond_s = (cmp_a_i == cmp_b_i);
      3'b001:  br_cond_s = (cmp_a_i != cmp_b_i);
      3'b100:  br_cond_s = ($signed(cmp_a_i) <  $signed(cmp_b_i));
      3'b101:  br_cond_s = ($signed(cmp_a_i) >= $signed(cmp_b_i));
      3'b110:  br_cond_s = (cmp_a_i <  cmp_b_i);
      3'b111:  br_cond_s = (cmp_a_i >= cmp_b_i);
      default: br_cond_s = 1'b0;
    endcase
  end

  // Next-PC selection and result mux for a single-cycle entry.
  always_comb begin
    pc_next_s  = pc_plus4_s;
    redirect_s = 1'b0;
    if (jalr_i) begin
      pc_next_s  = (alu_a_i + offset_i) & LSB_MASK;
      redirect_s = 1'b1;
    end else if (jal_i || (br_i && br_cond_s)) begin
      pc_next_s  = pc_i + offset_i;
      redirect_s = 1'b1;
    end else begin
      pc_next_s  = pc_plus4_s;
      redirect_s = 1'b0;
    end
    if (jal_i || jalr_i) begin
      result_s = pc_plus4_s;
    end else begin
      result_s = alu_res_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; flush aborts a running multiply.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && is_mul_s) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (flush_i || (cnt_r == CNT_ONE)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output logic: accept only when idle and the output slot frees up.
  always_comb begin
    if (state_r == IDLE) begin
      in_ready_o = ~out_valid_o | out_ready_i;
    end else begin
      in_ready_o = 1'b0;
    end
  end

  // Output register and multiplier datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      result_o    <= ZERO;
      pc_next_o   <= PC_RST;
      redirect_o  <= 1'b0;
      mcand_r     <= ZERO;
      mplier_r    <= ZERO;
      acc_r       <= ZERO;
      cnt_r       <= {CW{1'b0}};
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
      redirect_o  <= 1'b0;
      acc_r       <= ZERO;
      cnt_r       <= {CW{1'b0}};
    end else if (accept_s && is_mul_s) begin
      mcand_r     <= alu_a_i;
      mplier_r    <= alu_b_i;
      acc_r       <= ZERO;
      cnt_r       <= CNT_INIT;
      out_valid_o <= 1'b0;
      pc_next_o   <= pc_plus4_s;
      redirect_o  <= 1'b0;
    end else if (accept_s) begin
      out_valid_o <= 1'b1;
      result_o    <= result_s;
      pc_next_o   <= pc_next_s;
      redirect_o  <= redirect_s;
    end else if (state_r == BUSY) begin
      acc_r    <= acc_step_s;
      mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
      cnt_r    <= cnt_r - CNT_ONE;
      if (cnt_r == CNT_ONE) begin
        result_o    <= acc_step_s;
        out_valid_o <= 1'b1;
      end
    end else if (out_ready_i) begin
      // Drop redirect together with valid so it never shows on an empty slot.
      out_valid_o <= 1'b0;
      redirect_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_ex_pipe.sv
// Directed self-checking bench for riscv_ex_pipe; a second instance built
// without the multiplier checks the op-10-as-ADD fallback.
module tb_riscv_ex_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready, br, jal, jalr;
  logic [31:0] pc, alu_a, alu_b, cmp_a, cmp_b, offset;
  logic [3:0]  alu_op;
  logic [2:0]  br_cond;
  logic        in_ready, out_valid, redirect;
  logic [31:0] result, pc_next;
  logic        in_ready0, out_valid0, redirect0;
  logic [31:0] result0, pc_next0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  riscv_ex_pipe #(.XLEN(32), .MUL_EN(1'b1), .PC_RST(32'h0000_0080)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .pc_i(pc), .alu_op_i(alu_op), .alu_a_i(alu_a),
    .alu_b_i(alu_b), .cmp_a_i(cmp_a), .cmp_b_i(cmp_b), .offset_i(offset),
    .br_i(br), .br_cond_i(br_cond), .jal_i(jal), .jalr_i(jalr),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
    .pc_next_o(pc_next), .redirect_o(redirect));

  riscv_ex_pipe #(.XLEN(32), .MUL_EN(1'b0), .PC_RST(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready0), .pc_i(pc), .alu_op_i(alu_op), .alu_a_i(alu_a),
    .alu_b_i(alu_b), .cmp_a_i(cmp_a), .cmp_b_i(cmp_b), .offset_i(offset),
    .br_i(br), .br_cond_i(br_cond), .jal_i(jal), .jalr_i(jalr),
    .out_valid_o(out_valid0), .out_ready_i(out_ready), .result_o(result0),
    .pc_next_o(pc_next0), .redirect_o(redirect0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; br = 1'b0; jal = 1'b0; jalr = 1'b0;
    pc = 32'h0; alu_a = 32'h0; alu_b = 32'h0; cmp_a = 32'h0; cmp_b = 32'h0;
    offset = 32'h0; alu_op = 4'd0; br_cond = 3'b000;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 00000000", result); else pass_cnt++;
    total_cnt++; if (pc_next !== 32'h80) $display("FAIL reset_pc_next: got %h want 00000080", pc_next); else pass_cnt++;
    total_cnt++; if (redirect !== 1'b0) $display("FAIL reset_redirect: got %b want 0", redirect); else pass_cnt++;
    rst_n = 1'b1;
    step();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_add();
    alu_op = 4'd0; alu_a = 32'hFFFF_FFFF; alu_b = 32'h1; pc = 32'h10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL add_result: got %h want 00000000", result); else pass_cnt++;
    total_cnt++; if (pc_next !== 32'h14) $display("FAIL add_pc_next: got %h want 00000014", pc_next); else pass_cnt++;
    total_cnt++; if (redirect !== 1'b0) $display("FAIL add_redirect: got %b want 0", redirect); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL add_drain: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_alu();
    logic [3:0]  ops  [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15};
    logic [31:0] as   [10] = '{32'd5, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'h1, 32'h8000_0000,
                               32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] bs   [10] = '{32'd7, 32'h0FF0, 32'h0FF0, 32'h0FF0, 32'h21, 32'd4,
                               32'd4, 32'd1, 32'd1, 32'd3};
    logic [31:0] exps [10] = '{32'hFFFF_FFFE, 32'h00F0, 32'hFFF0, 32'hFF00, 32'h2, 32'h0800_0000,
                               32'hF800_0000, 32'h1, 32'h0, 32'd5};
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      alu_op = ops[i]; alu_a = as[i]; alu_b = bs[i]; pc = 32'h1000 + 32'(i * 4);
      step();
      total_cnt++;
      if (result !== exps[i] || out_valid !== 1'b1)
        $display("FAIL alu_op%0d: got %h valid %b want %h valid 1", ops[i], result, out_valid, exps[i]);
      else pass_cnt++;
    end
    in_valid = 1'b0; alu_op = 4'd0;
    step();
  endtask

  task automatic test_branch();
    logic [7:0]  taken = 8'b1010_0001;
    logic [31:0] want;
    br = 1'b1; cmp_a = 32'd5; cmp_b = 32'd5; pc = 32'h100; offset = 32'h20;
    alu_a = 32'd3; alu_b = 32'd4; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      br_cond = 3'(i);
      step();
      want = taken[i] ? 32'h120 : 32'h104;
      total_cnt++; if (redirect !== taken[i]) $display("FAIL br_cond%0d_redirect: got %b want %b", i, redirect, taken[i]); else pass_cnt++;
      total_cnt++; if (pc_next !== want) $display("FAIL br_cond%0d_pc_next: got %h want %h", i, pc_next, want); else pass_cnt++;
    end
    total_cnt++; if (result !== 32'd7) $display("FAIL br_result: got %h want 00000007", result); else pass_cnt++;
    cmp_a = 32'hFFFF_FFFF; cmp_b = 32'h1; offset = 32'hFFFF_FFF0; br_cond = 3'b100;
    step();
    total_cnt++; if (redirect !== 1'b1 || pc_next !== 32'hF0) $display("FAIL blt: got %b %h want 1 000000f0", redirect, pc_next); else pass_cnt++;
    br_cond = 3'b110;
    step();
    total_cnt++; if (redirect !== 1'b0 || pc_next !== 32'h104) $display("FAIL bltu: got %b %h want 0 00000104", redirect, pc_next); else pass_cnt++;
    in_valid = 1'b0; br = 1'b0;
    step();
  endtask

  task automatic test_jump();
    jalr = 1'b1; alu_a = 32'h203; offset = 32'h2; pc = 32'h40; in_valid = 1'b1;
    step();
    total_cnt++; if (pc_next !== 32'h204) $display("FAIL jalr_pc_next: got %h want 00000204", pc_next); else pass_cnt++;
    total_cnt++; if (result !== 32'h44) $display("FAIL jalr_result: got %h want 00000044", result); else pass_cnt++;
    total_cnt++; if (redirect !== 1'b1) $display("FAIL jalr_redirect: got %b want 1", redirect); else pass_cnt++;
    jal = 1'b1;
    step();
    total_cnt++; if (pc_next !== 32'h204) $display("FAIL jal_jalr_prio: got %h want 00000204", pc_next); else pass_cnt++;
    jalr = 1'b0;
    step();
    total_cnt++; if (pc_next !== 32'h42 || result !== 32'h44 || redirect !== 1'b1)
      $display("FAIL jal: got %h %h %b want 00000042 00000044 1", pc_next, result, redirect); else pass_cnt++;
    jal = 1'b0; in_valid = 1'b0; offset = 32'h0;
    step();
  endtask

  task automatic test_mul();
    int   cycles = 0;
    logic saw_ready = 1'b0;
    alu_op = 4'd10; alu_a = 32'd7; alu_b = 32'hFFFF_FFFF; pc = 32'h200; in_valid = 1'b1;
    step();
    in_valid = 1'b0; alu_op = 4'd0;
    total_cnt++; if (out_valid0 !== 1'b1 || result0 !== 32'd6) $display("FAIL mul_disabled: got %b %h want 1 00000006", out_valid0, result0); else pass_cnt++;
    while (out_valid !== 1'b1 && cycles < 40) begin
      if (in_ready !== 1'b0) saw_ready = 1'b1;
      step();
      cycles++;
    end
    total_cnt++; if (cycles !== 32) $display("FAIL mul_latency: got %0d want 32", cycles); else pass_cnt++;
    total_cnt++; if (saw_ready !== 1'b0) $display("FAIL mul_in_ready: got %b want 0", saw_ready); else pass_cnt++;
    total_cnt++; if (result !== 32'hFFFF_FFF9) $display("FAIL mul_result: got %h want fffffff9", result); else pass_cnt++;
    total_cnt++; if (pc_next !== 32'h204 || redirect !== 1'b0) $display("FAIL mul_pc: got %h %b want 00000204 0", pc_next, redirect); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL mul_drain: got %b %b want 0 1", out_valid, in_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic bad = 1'b0;
    out_ready = 1'b0; alu_op = 4'd0; alu_a = 32'd1; alu_b = 32'd2; pc = 32'h300; in_valid = 1'b1;
    step();
    alu_a = 32'd10; alu_b = 32'd20; pc = 32'h310;
    repeat (5) begin
      if (out_valid !== 1'b1 || result !== 32'd3 || in_ready !== 1'b0) bad = 1'b1;
      step();
    end
    total_cnt++; if (bad !== 1'b0 || result !== 32'd3) $display("FAIL bp_hold: got %b %h want 0 00000003", bad, result); else pass_cnt++;
    out_ready = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1 || result !== 32'd30 || pc_next !== 32'h314)
      $display("FAIL b2b_first: got %b %h %h want 1 0000001e 00000314", out_valid, result, pc_next); else pass_cnt++;
    alu_a = 32'd100; alu_b = 32'd1; pc = 32'h320;
    step();
    total_cnt++; if (out_valid !== 1'b1 || result !== 32'd101) $display("FAIL b2b_second: got %b %h want 1 00000065", out_valid, result); else pass_cnt++;
    in_valid = 1'b0;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_flush();
    int   cycles = 0;
    logic late = 1'b0;
    alu_op = 4'd10; alu_a = 32'd3; alu_b = 32'd5; pc = 32'h400; in_valid = 1'b1;
    step();
    in_valid = 1'b0; alu_op = 4'd0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_mul: got %b %b want 0 1", out_valid, in_ready); else pass_cnt++;
    repeat (30) begin
      if (out_valid !== 1'b0) late = 1'b1;
      step();
    end
    total_cnt++; if (late !== 1'b0) $display("FAIL flush_late_result: got %b want 0", late); else pass_cnt++;
    alu_op = 4'd10; in_valid = 1'b1;
    step();
    in_valid = 1'b0; alu_op = 4'd0;
    while (out_valid !== 1'b1 && cycles < 40) begin
      step();
      cycles++;
    end
    total_cnt++; if (cycles !== 32 || result !== 32'd15) $display("FAIL mul_after_flush: got %0d %h want 32 0000000f", cycles, result); else pass_cnt++;
    alu_a = 32'd1; alu_b = 32'd1; in_valid = 1'b1;
    step();
    alu_a = 32'd9; alu_b = 32'd0; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_output: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_mul();
    alu_op = 4'd10; alu_a = 32'd7; alu_b = 32'd3; pc = 32'h500; in_valid = 1'b1;
    step();
    in_valid = 1'b0; alu_op = 4'd0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    total_cnt++; if (pc_next !== 32'h80) $display("FAIL rst_async_pc_next: got %h want 00000080", pc_next); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_mid_mul: got %b %b want 0 1", out_valid, in_ready); else pass_cnt++;
    step();
    rst_n = 1'b1;
    repeat (40) step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_no_result: got %b want 0", out_valid); else pass_cnt++;
    alu_a = 32'd4; alu_b = 32'd4; pc = 32'h600; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total_cnt++; if (result !== 32'd8 || pc_next !== 32'h604) $display("FAIL rst_recover: got %h %h want 00000008 00000604", result, pc_next); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu();
    test_branch();
    test_jump();
    test_mul();
    test_back_to_back();
    test_flush();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
